ns_flop_set: RTL and testbench
==============================

// Module: ns_flop_set
// PURPOSE
// - Library bank of non-scan ("_ns") storage primitives used across JBI datapaths
//   and synchronizers (e.g. tx_en pipelining, CMP->JBus sync, FSM state regs).
// - One instance provides three independent SIZE-bit flop lanes sharing one clock:
//   plain D flop, D flop with load enable, D flop with async active-low clear.
// - No scan muxing, no test ports; pure rising-edge storage.
// PARAMETERS
// - SIZE  1  bit width of every lane (legal 1..64); all lanes share it
// PORTS
// - clk     in   1     sole clock; all lanes sample on rising edge
// - rst_l   in   1     asynchronous, active-low reset; affects reset lane only
// - d_din   in   SIZE  plain lane data in
// - d_q     out  SIZE  plain lane data out
// - e_din   in   SIZE  enable lane data in
// - e_en    in   1     enable lane load enable, active high
// - e_q     out  SIZE  enable lane data out
// - r_din   in   SIZE  reset lane data in
// - r_q     out  SIZE  reset lane data out
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low (clk, rst_l).
// - Plain lane: d_q <= d_din on every posedge clk; latency 1 cycle; no reset,
//   d_q is X from power-up until the first clock edge; rst_l has no effect on it.
// - Enable lane: on posedge clk, e_q <= e_din if e_en==1, else e_q holds;
//   no reset; X until first edge with e_en==1; e_en X -> e_q X in simulation.
// - Reset lane: rst_l falling (or held 0) forces r_q = {SIZE{1'b0}} immediately,
//   independent of clk; while rst_l==0 clock edges are ignored.
//   With rst_l==1, r_q <= r_din on posedge clk.
// - Reset deassertion coincident with a clk edge: that edge is not captured;
//   first load is the next rising edge (deassert synchronously in the system).
// - Reset mid-operation: r_q clears within the same delta, other lanes unaffected.
// - Outputs are the flop Q directly; no combinational path din->q.
// - Widths: all buses exactly SIZE bits, no extension or truncation.
// STRUCTURE
// - No shared package required; SIZE is the only constant.
// - One natural sub-module: ns_flop_cell (1 storage vector, mode chosen by
//   localparams PLAIN/ENABLE/ASYNC_CLR) instantiated three times; alternatively
//   three always blocks inline.
// - Reset lane always block: @(posedge clk or negedge rst_l).
// TESTING
// - SIZE=2, rst_l=0 then 1, r_din=2'b11 at edge 1 -> r_q 2'b00 during reset,
//   2'b11 one cycle after first post-reset edge.
// - Plain lane: d_din sequence 1,0,1 on successive edges -> d_q follows one cycle
//   later; rst_l pulsed low mid-stream leaves d_q unchanged.
// - Enable lane: e_din=1,e_en=1 -> e_q=1; then e_din=0,e_en=0 for 3 edges ->
//   e_q stays 1; e_en=1 -> e_q=0 next edge.
// - Async clear: r_q=2'b10, drop rst_l between edges -> r_q=2'b00 before next edge;
//   edges while rst_l=0 with r_din=2'b11 -> r_q stays 2'b00.
// - SIZE=64 walking-ones on all lanes -> each q equals prior-cycle din bit-exact;
//   check no bit cross-talk between lanes.

Source files
------------

// File: rtl/ns_flop_set_pkg.sv
// ============================================================================
// ns_flop_set_pkg : storage-mode encoding shared by the non-scan flop bank.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ns_flop_set_pkg;

    typedef enum logic [1:0] {
        PLAIN     = 2'd0,
        ENABLE    = 2'd1,
        ASYNC_CLR = 2'd2
    } cell_mode_e;

endpackage : ns_flop_set_pkg

`default_nettype wire

// File: rtl/ns_flop_set_if.sv
// ============================================================================
// ns_flop_set_if : data/enable bundle for the three flop lanes of ns_flop_set.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ns_flop_set_if #(
    parameter int SIZE = 1
);
    logic [SIZE-1:0] d_din;
    logic [SIZE-1:0] d_q;
    logic [SIZE-1:0] e_din;
    logic            e_en;
    logic [SIZE-1:0] e_q;
    logic [SIZE-1:0] r_din;
    logic [SIZE-1:0] r_q;

    modport master (
        output d_din, e_din, e_en, r_din,
        input  d_q, e_q, r_q
    );

    modport slave (
        input  d_din, e_din, e_en, r_din,
        output d_q, e_q, r_q
    );

endinterface : ns_flop_set_if

`default_nettype wire

// File: rtl/ns_flop_set_cell.sv
// ============================================================================
// ns_flop_set_cell : one SIZE-bit rising-edge storage vector; MODE selects
// plain, load-enable or async-clear behaviour. Revision: 1.0
// ============================================================================
`default_nettype none

module ns_flop_set_cell
    import ns_flop_set_pkg::*;
#(
    parameter int         SIZE = 1,
    parameter cell_mode_e MODE = PLAIN
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            en_i,
    input  logic [SIZE-1:0] din_i,
    output logic [SIZE-1:0] q_o
);

    logic [SIZE-1:0] data_q;
    logic [SIZE-1:0] data_d;

    generate
        if (MODE == ENABLE) begin : g_enable
            logic unused_rst;
            assign unused_rst = rst_l;

            // Ternary (not if/else) so an unknown enable yields unknown data.
            always_comb begin
                data_d = en_i ? din_i : data_q;
            end

            always_ff @(posedge clk) begin
                data_q <= data_d;
            end
        end else if (MODE == ASYNC_CLR) begin : g_async_clr
            logic unused_en;
            assign unused_en = en_i;

            always_comb begin
                data_d = din_i;
            end

            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end
        end else begin : g_plain
            logic unused_ctl;
            assign unused_ctl = rst_l ^ en_i;

            always_comb begin
                data_d = din_i;
            end

            always_ff @(posedge clk) begin
                data_q <= data_d;
            end
        end
    endgenerate

    assign q_o = data_q;

endmodule : ns_flop_set_cell

`default_nettype wire

// File: rtl/ns_flop_set.sv
// ============================================================================
// ns_flop_set : bank of three independent non-scan SIZE-bit flop lanes
// (plain, load-enable, async active-low clear) on one clock. Revision: 1.0
// ============================================================================
`default_nettype none

module ns_flop_set
    import ns_flop_set_pkg::*;
#(
    parameter int SIZE = 1
) (
    input  logic          clk,
    input  logic          rst_l,
    ns_flop_set_if.slave  bus
);

    ns_flop_set_cell #(
        .SIZE (SIZE),
        .MODE (PLAIN)
    ) u_plain (
        .clk   (clk),
        .rst_l (1'b1),
        .en_i  (1'b1),
        .din_i (bus.d_din),
        .q_o   (bus.d_q)
    );

    ns_flop_set_cell #(
        .SIZE (SIZE),
        .MODE (ENABLE)
    ) u_enable (
        .clk   (clk),
        .rst_l (1'b1),
        .en_i  (bus.e_en),
        .din_i (bus.e_din),
        .q_o   (bus.e_q)
    );

    // Only this lane observes rst_l; the other two are reset-free by design.
    ns_flop_set_cell #(
        .SIZE (SIZE),
        .MODE (ASYNC_CLR)
    ) u_async_clr (
        .clk   (clk),
        .rst_l (rst_l),
        .en_i  (1'b1),
        .din_i (bus.r_din),
        .q_o   (bus.r_q)
    );

endmodule : ns_flop_set

`default_nettype wire

// File: tb/tb_ns_flop_set.sv
// ============================================================================
// tb_ns_flop_set : self-checking bench for ns_flop_set at SIZE=2 and SIZE=64.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ns_flop_set;

    logic clk;
    logic rst_l;

    int total = 0;
    int bad   = 0;

    ns_flop_set_if #(.SIZE(2))  bus_a ();
    ns_flop_set_if #(.SIZE(64)) bus_b ();

    ns_flop_set #(.SIZE(2)) u_dut_a (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus_a)
    );

    ns_flop_set #(.SIZE(64)) u_dut_b (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] d;
        logic [1:0] e;
        logic       en;
        logic [1:0] r;
        logic       rst;
        logic [1:0] xd;
        logic [1:0] xe;
        logic [1:0] xr;
    } vec_t;

    typedef struct {
        logic [1:0] xd;
        logic [1:0] xe;
        logic [1:0] xr;
    } exp2_t;

    typedef struct {
        logic [63:0] xd;
        logic [63:0] xe;
        logic [63:0] xr;
    } exp64_t;

    exp2_t  sb_a [$];
    exp64_t sb_b [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_a(input string tag);
        exp2_t x;
        x = sb_a.pop_front();
        chk({tag, ".d_q"}, 64'(bus_a.d_q), 64'(x.xd));
        chk({tag, ".e_q"}, 64'(bus_a.e_q), 64'(x.xe));
        chk({tag, ".r_q"}, 64'(bus_a.r_q), 64'(x.xr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vecs [7];
        logic [63:0] e_model;
        exp64_t x64;

        // Expected values are q after the rising edge that follows the drive.
        vecs[0] = '{d:2'd1, e:2'd1, en:1'b1, r:2'd3, rst:1'b0, xd:2'd1, xe:2'd1, xr:2'd0};
        vecs[1] = '{d:2'd0, e:2'd0, en:1'b0, r:2'd3, rst:1'b1, xd:2'd0, xe:2'd1, xr:2'd3};
        vecs[2] = '{d:2'd1, e:2'd0, en:1'b0, r:2'd1, rst:1'b1, xd:2'd1, xe:2'd1, xr:2'd1};
        vecs[3] = '{d:2'd0, e:2'd0, en:1'b0, r:2'd0, rst:1'b1, xd:2'd0, xe:2'd1, xr:2'd0};
        vecs[4] = '{d:2'd1, e:2'd0, en:1'b1, r:2'd1, rst:1'b1, xd:2'd1, xe:2'd0, xr:2'd1};
        vecs[5] = '{d:2'd2, e:2'd3, en:1'b1, r:2'd3, rst:1'b1, xd:2'd2, xe:2'd3, xr:2'd3};
        vecs[6] = '{d:2'd1, e:2'd2, en:1'b0, r:2'd2, rst:1'b1, xd:2'd1, xe:2'd3, xr:2'd2};

        rst_l       = 1'b1;
        bus_a.d_din = '0; bus_a.e_din = '0; bus_a.e_en = 1'b0; bus_a.r_din = '0;
        bus_b.d_din = '0; bus_b.e_din = '0; bus_b.e_en = 1'b0; bus_b.r_din = '0;
        #1 rst_l = 1'b0;
        #1;
        chk("reset_a.r_q", 64'(bus_a.r_q), 64'd0);
        chk("reset_b.r_q", bus_b.r_q, 64'd0);

        // Table-driven vectors through the scoreboard.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (sb_a.size() != 0) cmp_a($sformatf("vec%0d", i - 1));
            bus_a.d_din = vecs[i].d;
            bus_a.e_din = vecs[i].e;
            bus_a.e_en  = vecs[i].en;
            bus_a.r_din = vecs[i].r;
            rst_l       = vecs[i].rst;
            sb_a.push_back('{xd:vecs[i].xd, xe:vecs[i].xe, xr:vecs[i].xr});
        end
        @(negedge clk);
        cmp_a("vec6");

        // Async clear between edges: r_q=10 drops to 00 before the next edge.
        #2 rst_l = 1'b0;
        #1;
        chk("aclr.r_q", 64'(bus_a.r_q), 64'd0);
        chk("aclr.d_q", 64'(bus_a.d_q), 64'd1);
        chk("aclr.e_q", 64'(bus_a.e_q), 64'd3);
        bus_a.r_din = 2'd3;
        bus_a.d_din = 2'd2;
        bus_a.e_en  = 1'b0;
        @(negedge clk);
        chk("rst_hold1.r_q", 64'(bus_a.r_q), 64'd0);
        chk("rst_hold1.d_q", 64'(bus_a.d_q), 64'd2);
        chk("rst_hold1.e_q", 64'(bus_a.e_q), 64'd3);
        bus_a.d_din = 2'd1;
        @(negedge clk);
        chk("rst_hold2.r_q", 64'(bus_a.r_q), 64'd0);
        chk("rst_hold2.d_q", 64'(bus_a.d_q), 64'd1);
        rst_l       = 1'b1;
        bus_a.r_din = 2'd1;
        @(negedge clk);
        chk("rst_release.r_q", 64'(bus_a.r_q), 64'd1);

        // SIZE=64 walking ones with distinct bit positions per lane.
        e_model = '0;
        for (int i = 0; i <= 64; i++) begin
            @(negedge clk);
            if (sb_b.size() != 0) begin
                x64 = sb_b.pop_front();
                chk($sformatf("walk%0d.d_q", i - 1), bus_b.d_q, x64.xd);
                chk($sformatf("walk%0d.e_q", i - 1), bus_b.e_q, x64.xe);
                chk($sformatf("walk%0d.r_q", i - 1), bus_b.r_q, x64.xr);
            end
            if (i < 64) begin
                bus_b.d_din = 64'd1 << i;
                bus_b.e_din = 64'd1 << ((i + 21) % 64);
                bus_b.r_din = 64'd1 << ((i + 42) % 64);
                bus_b.e_en  = ((i % 4) != 3);
                if (bus_b.e_en) e_model = bus_b.e_din;
                sb_b.push_back('{xd:bus_b.d_din, xe:e_model, xr:bus_b.r_din});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ns_flop_set

`default_nettype wire
